// File: rtl/data_mem_access_sequencer.sv
// data_mem_access_sequencer
//   Splits RV32 loads/stores (B/H/W, signed/unsigned) into aligned beats on a
//   MEM_BYTES-wide data memory port, assembling and extending load data.
//   Misaligned accesses may span several beats (or are rejected when
//   ALLOW_MISALIGNED is 0).
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   cpu_read/write    load/store request, qualified by inst_hit
//   cpu_funct3        000 B, 001 H, 010 W, 100 BU, 101 HU
//   cpu_address       byte address; cpu_writedata LSB-aligned store data
//   cpu_readdata      extended load result (registered)
//   cpu_busywait      pipeline stall; cpu_error one-cycle illegal-request pulse
//   mem_read/write    memory strobes; mem_address beat base (MEM_BYTES aligned)
//   mem_byteenable    active lanes; mem_writedata lane-positioned store data
//   mem_readdata      read data; mem_busywait memory stall
module data_mem_access_sequencer #(
  parameter int MEM_BYTES        = 1,
  parameter int ALLOW_MISALIGNED = 1,
  parameter int ADDR_W           = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic                   inst_hit,
  input  logic [2:0]             cpu_funct3,
  input  logic [ADDR_W-1:0]      cpu_address,
  input  logic [31:0]            cpu_writedata,
  output logic [31:0]            cpu_readdata,
  output logic                   cpu_busywait,
  output logic                   cpu_error,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ADDR_W-1:0]      mem_address,
  output logic [MEM_BYTES-1:0]   mem_byteenable,
  output logic [8*MEM_BYTES-1:0] mem_writedata,
  input  logic [8*MEM_BYTES-1:0] mem_readdata,
  input  logic                   mem_busywait
);

  localparam int                SH        = (MEM_BYTES == 4) ? 2 : ((MEM_BYTES == 2) ? 1 : 0);
  localparam logic [1:0]        LOW_MASK  = 2'(MEM_BYTES - 1);
  localparam logic [ADDR_W-1:0] BEAT_MASK = ~(ADDR_W'(MEM_BYTES - 1));

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [2:0]        funct3_r;
  logic [31:0]       wdata_r;
  logic              is_read_r;
  logic [1:0]        beat_r;
  logic [1:0]        last_r;
  logic [31:0]       stage_r;

  logic              req_s, f3_ok_s, mis_s, illegal_s, accept_s;
  logic [ADDR_W-1:0] src_addr_s;
  logic [2:0]        src_f3_s;
  logic [31:0]       src_wd_s;
  logic [1:0]        k_s, src_low_s, cur_low_s, last_s;
  logic [2:0]        src_size_s, cur_size_s;
  logic [3:0]        last_full_s;
  logic [ADDR_W-1:0] nxt_addr_s;
  logic [MEM_BYTES-1:0]   nxt_be_s;
  logic [8*MEM_BYTES-1:0] nxt_wd_s;
  logic [31:0]       stage_nxt_s;

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  // Position of lane i of beat k, counted in bytes from the first beat base.
  function automatic logic [3:0] pos_of(input logic [1:0] k, input int i);
    pos_of = ({2'b00, k} << SH) + 4'(i);
  endfunction

  function automatic logic lane_en(input logic [1:0] a_low, input logic [2:0] size,
                                   input logic [3:0] pos);
    lane_en = (pos >= {2'b00, a_low}) && ((pos - {2'b00, a_low}) < {1'b0, size});
  endfunction

  // Byte offset within the request (0..3) carried by an enabled lane.
  function automatic logic [1:0] lane_off(input logic [1:0] a_low, input logic [3:0] pos);
    logic [3:0] d;
    d = pos - {2'b00, a_low};
    lane_off = d[1:0];
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] s);
    case (f3)
      3'b000:  extend = {{24{s[7]}}, s[7:0]};
      3'b001:  extend = {{16{s[15]}}, s[15:0]};
      3'b100:  extend = {24'h000000, s[7:0]};
      3'b101:  extend = {16'h0000, s[15:0]};
      default: extend = s;
    endcase
  endfunction

  // Request qualification and legality.
  always_comb begin
    req_s = inst_hit & (cpu_read ^ cpu_write);
    case (cpu_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok_s = 1'b1;
      default:                                f3_ok_s = 1'b0;
    endcase
    mis_s = ((cpu_funct3[1:0] == 2'b01) & cpu_address[0]) |
            ((cpu_funct3[1:0] == 2'b10) & (cpu_address[1:0] != 2'b00));
    illegal_s = (inst_hit & cpu_read & cpu_write) |
                (req_s & (~f3_ok_s | (cpu_write & cpu_funct3[2]) |
                          (mis_s & (ALLOW_MISALIGNED == 0))));
    accept_s = req_s & ~illegal_s;
  end

  // Beat to present after the next edge: beat 0 of the incoming request in
  // IDLE, otherwise the following beat of the latched request.
  always_comb begin
    if (state_r == IDLE) begin
      src_addr_s = cpu_address;
      src_f3_s   = cpu_funct3;
      src_wd_s   = cpu_writedata;
      k_s        = 2'd0;
    end else begin
      src_addr_s = addr_r;
      src_f3_s   = funct3_r;
      src_wd_s   = wdata_r;
      k_s        = beat_r + 2'd1;
    end
    src_low_s   = src_addr_s[1:0] & LOW_MASK;
    src_size_s  = size_of(src_f3_s);
    last_full_s = ({2'b00, src_low_s} + {1'b0, src_size_s} - 4'd1) >> SH;
    last_s      = last_full_s[1:0];
    nxt_addr_s  = (src_addr_s & BEAT_MASK) + (ADDR_W'(k_s) << SH);
    nxt_be_s    = '0;
    nxt_wd_s    = '0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      nxt_be_s[i]       = lane_en(src_low_s, src_size_s, pos_of(k_s, i));
      nxt_wd_s[8*i +: 8] = nxt_be_s[i] ?
          src_wd_s[{lane_off(src_low_s, pos_of(k_s, i)), 3'b000} +: 8] : 8'h00;
    end
  end

  // Staging register contents after capturing the enabled lanes of the current beat.
  always_comb begin
    cur_low_s   = addr_r[1:0] & LOW_MASK;
    cur_size_s  = size_of(funct3_r);
    stage_nxt_s = stage_r;
    for (int i = 0; i < MEM_BYTES; i++) begin
      stage_nxt_s[{lane_off(cur_low_s, pos_of(beat_r, i)), 3'b000} +: 8] =
          lane_en(cur_low_s, cur_size_s, pos_of(beat_r, i)) ?
          mem_readdata[8*i +: 8] :
          stage_nxt_s[{lane_off(cur_low_s, pos_of(beat_r, i)), 3'b000} +: 8];
    end
  end

  // Stall is combinational in IDLE so the pipeline freezes in the request cycle.
  assign cpu_busywait = (state_r == ACCESS) | ((state_r == IDLE) & accept_s);

  // Sequencer FSM with registered memory-side and CPU-side outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      addr_r         <= '0;
      funct3_r       <= 3'd0;
      wdata_r        <= 32'h0;
      is_read_r      <= 1'b0;
      beat_r         <= 2'd0;
      last_r         <= 2'd0;
      stage_r        <= 32'h0;
      cpu_readdata   <= 32'h0;
      cpu_error      <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          cpu_error <= illegal_s;
          if (accept_s) begin
            addr_r         <= cpu_address;
            funct3_r       <= cpu_funct3;
            wdata_r        <= cpu_writedata;
            is_read_r      <= cpu_read;
            beat_r         <= 2'd0;
            last_r         <= last_s;
            stage_r        <= 32'h0;
            mem_read       <= cpu_read;
            mem_write      <= cpu_write;
            mem_address    <= nxt_addr_s;
            mem_byteenable <= nxt_be_s;
            mem_writedata  <= nxt_wd_s;
            state_r        <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          cpu_error <= 1'b0;
          if (!mem_busywait) begin
            stage_r <= stage_nxt_s;
            if (beat_r == last_r) begin
              mem_read       <= 1'b0;
              mem_write      <= 1'b0;
              mem_byteenable <= '0;
              mem_writedata  <= '0;
              if (is_read_r) begin
                cpu_readdata <= extend(funct3_r, stage_nxt_s);
              end else begin
                cpu_readdata <= cpu_readdata;
              end
              state_r <= DONE;
            end else begin
              beat_r         <= beat_r + 2'd1;
              mem_address    <= nxt_addr_s;
              mem_byteenable <= nxt_be_s;
              mem_writedata  <= nxt_wd_s;
            end
          end else begin
            state_r <= ACCESS;
          end
        end
        DONE: begin
          cpu_error <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          cpu_error <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/data_mem_access_sequencer.md
Name: data_mem_access_sequencer

Overview:
Parametrised successor to the byte-serial data-cache front end. It sits between the MEM stage and a data memory of configurable width (MEM_BYTES lanes). It splits each RV32 load/store (byte/half/word, signed or unsigned) into one or more aligned memory beats with byte enables, and supports misaligned accesses that span beats. For loads it assembles the data and sign- or zero-extends it; it stalls the pipeline through cpu_busywait until the access completes.

Parameters:
MEM_BYTES, 1, memory port width in bytes; legal values 1, 2, 4.
ALLOW_MISALIGNED, 1, 1 = split misaligned accesses across beats; 0 = reject them with cpu_error.
ADDR_W, 32, byte-address width.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
cpu_read  in  1  load request.
cpu_write  in  1  store request.
inst_hit  in  1  instruction valid qualifier; requests are ignored while it is low.
cpu_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
cpu_address  in  ADDR_W  byte address.
cpu_writedata  in  32  store data, LSB-aligned.
cpu_readdata  out  32  extended load result, registered.
cpu_busywait  out  1  stall to pipeline.
cpu_error  out  1  one-cycle pulse on an illegal request.
mem_read  out  1  memory read strobe.
mem_write  out  1  memory write strobe.
mem_address  out  ADDR_W  beat address, aligned to MEM_BYTES.
mem_byteenable  out  MEM_BYTES  active lanes of the current beat.
mem_writedata  out  8*MEM_BYTES  lane-positioned store data.
mem_readdata  in  8*MEM_BYTES  read data; valid when mem_busywait is low.
mem_busywait  in  1  memory stall; a beat completes at a rising edge where the strobe is high and mem_busywait is low.

Behaviour:
- Reset (asynchronous): state IDLE. cpu_readdata=0, cpu_busywait=0, cpu_error=0, mem_read=0, mem_write=0, mem_byteenable=0, mem_address=0, mem_writedata=0. A reset mid-access drops the strobes immediately and discards the transaction.
- Request condition req = inst_hit & (cpu_read ^ cpu_write). cpu_read and cpu_write both high is illegal.
- Size: B=1, H=2, W=4 bytes. Covered span is [A, A+size-1]. Beats run from floor(A/MEM_BYTES) to floor((A+size-1)/MEM_BYTES), so there are 1 to 4 beats.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - On req, cpu_busywait=1 combinationally in the same cycle. The request (address, funct3, data, direction) is latched at the edge, beat index is set to 0, and the FSM moves to ACCESS.
  - Illegal request: cpu_busywait=0; cpu_error pulses for one cycle after the edge; no memory strobe; the FSM stays in IDLE. Illegal means read&write with inst_hit high, an undefined funct3, a store with funct3 BU or HU, or a misaligned access when ALLOW_MISALIGNED=0.
- ACCESS:
  - cpu_busywait=1. Exactly one of mem_read/mem_write is high.
  - mem_address is the current beat base. Lane i is enabled iff byte beat_base+i lies in the covered span. For an enabled lane, mem_writedata lane i = cpu_writedata byte (beat_base+i-A); disabled lanes are driven 0.
  - At an edge with mem_busywait=0: enabled read lanes are captured into the staging register, the beat index increments, and the next beat's address is presented in the following cycle. The strobe is not deasserted between beats.
  - After the last beat completes, the FSM moves to DONE.
- DONE (one cycle):
  - Strobes are low and cpu_busywait=0.
  - For a load, cpu_readdata is updated at the edge entering DONE: B/H sign-extend from bit 7/15, BU/HU zero-extend, W passes through. cpu_readdata holds its value until the next load completes; stores leave it unchanged.
  - At the end of the DONE cycle the FSM returns to IDLE unconditionally; the still-asserted request is not re-accepted.
- Latency: with zero memory wait states and N beats, cpu_busywait is high for N+1 cycles. Each memory wait cycle adds one. Back-to-back requests see one IDLE bubble.
- Request inputs are ignored while the FSM is in ACCESS or DONE, so a change to cpu_address in flight has no effect.

Test Plan:
- MEM_BYTES=1, SW A=0x100, D=0xA1B2C3D4 → 4 write beats at 0x100..0x103 with data D4,C3,B2,A1 and byteenable 1; busywait high for 5 cycles.
- MEM_BYTES=4, LB A=0x203, mem[0x200]=0x80FFFFFF → 1 beat, byteenable 1000, cpu_readdata=0xFFFFFF80. Repeat with LBU → 0x00000080.
- MEM_BYTES=4, ALLOW_MISALIGNED=1, LW A=0x302, mem[0x300]=0x2211xxxx, mem[0x304]=0xxxxx4433 → beats at 0x300 (1100) and 0x304 (0011), cpu_readdata=0x44332211.
- MEM_BYTES=2, SH A=0x11, mem_busywait high for 3 cycles per beat → beats at 0x10 (10) and 0x12 (01); busywait high for 1+2×4=9 cycles.
- ALLOW_MISALIGNED=0 LH A=0x1; cpu_read&cpu_write both high; SBU funct3=100 → each gives a cpu_error pulse, no strobe, busywait 0. inst_hit=0 with a request → no action.
- Assert reset during beat 2 of a 4-beat SW → mem_write=0 immediately; FSM in IDLE; a following LW completes normally.
